// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// APB initiator. It turns single-beat commands from a local requester into
// APB SETUP/ACCESS transfers. For each command it returns the read data and
// the error status as a one-cycle response pulse. An ACCESS-phase timeout
// aborts the transfer when the slave never raises pready.
//
// Command handshake: a command transfers on a rising edge where cmd_valid_i
// and cmd_ready_o are both high. cmd_ready_o is high only in IDLE, so at most
// one transfer is in flight and nothing is queued. The response side has no
// backpressure: rsp_valid_o is high for exactly one cycle per accepted
// command, and rsp_rdata_o/rsp_err_o/rsp_timeout_o hold until the next
// response.
module apb_master_bridge #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // local command / response side
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    // APB side
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    // debug: current FSM state (0 = IDLE, 1 = SETUP, 2 = ACCESS)
    output logic [1:0]            state_o
);

    // A value of 0 for TIMEOUT_CYCLES disables the timeout. The counter still
    // exists (1 bit wide) so the logic keeps the same shape, but it never
    // advances.
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1)
                                                                 : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;

    // One-cycle event strobes that the next-state logic decodes
    logic accept;    // command taken this cycle
    logic complete;  // slave answered with pready in ACCESS
    logic abort;     // ACCESS ran out of cycles without pready

    // State register; an asynchronous reset drops any transfer in flight
    // without producing a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle event strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // SETUP always lasts exactly one cycle. pready/pslverr are not looked at here.
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    // A pready on the last allowed cycle still counts as a normal completion
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // APB control strobes and the command-ready signal come straight from the state
    always_comb begin
        cmd_ready_o = (state == ST_IDLE);
        psel_o      = (state != ST_IDLE);
        penable_o   = (state == ST_ACCESS);
        state_o     = state;
    end

    // ACCESS wait counter: it is cleared when leaving SETUP and advances on
    // every ACCESS cycle without pready. It reaches CNT_LAST on the final
    // ACCESS cycle that is allowed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (TIMEOUT_EN && (state == ST_ACCESS) && !pready_i && !abort) begin
            wait_cnt <= wait_cnt + CNT_ONE;
        end
    end

    // APB address/data registers. They are loaded only when a command is
    // accepted, so they stay stable through SETUP and ACCESS and keep their
    // last value while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_o  <= '0;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
        end else if (accept) begin
            paddr_o  <= cmd_addr_i;
            pwrite_o <= cmd_write_i;
            pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
        end
    end

    // Response registers: the valid bit is a single-cycle pulse, and the
    // payload fields hold until the next completion or abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (complete) begin
                rsp_valid_o   <= 1'b1;
                rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                rsp_err_o     <= pslverr_i;
                rsp_timeout_o <= 1'b0;
            end else if (abort) begin
                rsp_valid_o   <= 1'b1;
                rsp_rdata_o   <= '0;
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for apb_master_bridge. The bench drives inputs and samples
// outputs 1 ns after each rising clock edge. Every expected value is written
// out by hand from the bus protocol timing.
module tb_apb_master_bridge;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    apb_master_bridge #(
        .BUS_WIDTH     (32),
        .ADDR_WIDTH    (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .paddr_o      (paddr),
        .pwdata_o     (pwdata),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr),
        .state_o      (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present a command in the current (IDLE) cycle. The caller decides when to drop valid.
    task automatic drive_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    logic [15:0] v_addr  [4];
    logic        v_write [4];
    logic [31:0] v_wdata [4];
    logic [31:0] v_rdata [4];
    int          acc_cycles;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_psel", psel, 1'b0);
        chk1("rst_penable", penable, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_paddr", 32'(paddr), 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- 1: zero-wait write ----------------
        drive_cmd(1'b1, 16'h0010, 32'hDEADBEEF);
        pready = 1'b1;
        chk1("t1_ready_idle", cmd_ready, 1'b1);
        tick();  // N+1 SETUP
        // The ready is low here, so this different command must be ignored
        drive_cmd(1'b0, 16'h0BAD, 32'h0BAD0BAD);
        chk1("t1_setup_psel", psel, 1'b1);
        chk1("t1_setup_penable", penable, 1'b0);
        chk1("t1_setup_ready", cmd_ready, 1'b0);
        chk("t1_paddr", 32'(paddr), 32'h0010);
        chk1("t1_pwrite", pwrite, 1'b1);
        chk("t1_pwdata", pwdata, 32'hDEADBEEF);
        tick();  // N+2 ACCESS
        cmd_valid = 1'b0;
        chk1("t1_access_psel", psel, 1'b1);
        chk1("t1_access_penable", penable, 1'b1);
        chk("t1_access_paddr", 32'(paddr), 32'h0010);
        chk1("t1_access_rsp_valid", rsp_valid, 1'b0);
        tick();  // N+3 response
        chk1("t1_rsp_valid", rsp_valid, 1'b1);
        chk1("t1_rsp_err", rsp_err, 1'b0);
        chk1("t1_rsp_timeout", rsp_timeout, 1'b0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk1("t1_psel_drop", psel, 1'b0);
        chk1("t1_ready_back", cmd_ready, 1'b1);
        tick();
        chk1("t1_rsp_pulse_end", rsp_valid, 1'b0);
        chk("t1_paddr_hold", 32'(paddr), 32'h0010);
        chk("t1_pwdata_hold", pwdata, 32'hDEADBEEF);

        // ---------------- 2: read with 3 wait states ----------------
        drive_cmd(1'b0, 16'h0004, 32'hFFFFFFFF);
        pready = 1'b0;
        prdata = 32'hBAADBAAD;
        tick();  // N+1 SETUP
        cmd_valid = 1'b0;
        chk("t2_setup_paddr", 32'(paddr), 32'h0004);
        chk("t2_pwdata_read", pwdata, 32'h0);
        chk1("t2_pwrite", pwrite, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();  // N+2..N+4 ACCESS, no ready
            chk1("t2_wait_penable", penable, 1'b1);
            chk("t2_wait_paddr", 32'(paddr), 32'h0004);
            chk1("t2_wait_rsp_valid", rsp_valid, 1'b0);
        end
        tick();  // N+5 ACCESS with ready
        pready = 1'b1;
        prdata = 32'h12345678;
        chk1("t2_last_penable", penable, 1'b1);
        chk("t2_last_paddr", 32'(paddr), 32'h0004);
        tick();  // N+6 response
        pready = 1'b0;
        chk1("t2_rsp_valid", rsp_valid, 1'b1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
        chk1("t2_rsp_err", rsp_err, 1'b0);
        tick();

        // ---------------- 3: read with slave error ----------------
        drive_cmd(1'b0, 16'h0020, 32'h0);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFEF00D;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk1("t3_rsp_valid", rsp_valid, 1'b1);
        chk1("t3_rsp_err", rsp_err, 1'b1);
        chk1("t3_rsp_timeout", rsp_timeout, 1'b0);
        chk("t3_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        pslverr = 1'b0;
        tick();
        chk1("t3_err_hold", rsp_err, 1'b1);
        chk("t3_rdata_hold", rsp_rdata, 32'hCAFEF00D);

        // ---------------- 4: timeout after 16 ACCESS cycles ----------------
        drive_cmd(1'b0, 16'h0024, 32'h0);
        pready = 1'b0;
        prdata = 32'h55AA55AA;
        tick();  // SETUP
        cmd_valid  = 1'b0;
        acc_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (penable) acc_cycles++;
            else break;
        end
        chk("t4_access_cycles", 32'(acc_cycles), 32'd16);
        chk1("t4_rsp_valid", rsp_valid, 1'b1);
        chk1("t4_rsp_err", rsp_err, 1'b1);
        chk1("t4_rsp_timeout", rsp_timeout, 1'b1);
        chk("t4_rsp_rdata", rsp_rdata, 32'h0);
        chk1("t4_ready_back", cmd_ready, 1'b1);
        // the next command completes normally
        drive_cmd(1'b1, 16'h0030, 32'hA5A5A5A5);
        pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk1("t4_next_rsp_valid", rsp_valid, 1'b1);
        chk1("t4_next_rsp_err", rsp_err, 1'b0);
        chk1("t4_next_rsp_timeout", rsp_timeout, 1'b0);
        chk("t4_next_rsp_rdata", rsp_rdata, 32'h0);
        tick();

        // ---------------- 5: back-to-back, valid held high ----------------
        v_addr[0] = 16'h0100; v_write[0] = 1'b1; v_wdata[0] = 32'h11111111; v_rdata[0] = 32'hEEEEEEEE;
        v_addr[1] = 16'h0104; v_write[1] = 1'b0; v_wdata[1] = 32'h99999999; v_rdata[1] = 32'h22222222;
        v_addr[2] = 16'h0108; v_write[2] = 1'b1; v_wdata[2] = 32'h33333333; v_rdata[2] = 32'hDDDDDDDD;
        v_addr[3] = 16'h010C; v_write[3] = 1'b0; v_wdata[3] = 32'h88888888; v_rdata[3] = 32'h44444444;
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(v_write[k], v_addr[k], v_wdata[k]);
            prdata = v_rdata[k];
            chk1("t5_ready", cmd_ready, 1'b1);
            tick();  // SETUP
            chk1("t5_setup_psel", psel, 1'b1);
            chk1("t5_setup_penable", penable, 1'b0);
            chk("t5_paddr", 32'(paddr), 32'(v_addr[k]));
            chk1("t5_pwrite", pwrite, v_write[k]);
            chk("t5_pwdata", pwdata, v_write[k] ? v_wdata[k] : 32'h0);
            tick();  // ACCESS
            chk1("t5_access_penable", penable, 1'b1);
            tick();  // response, IDLE again
            chk1("t5_rsp_valid", rsp_valid, 1'b1);
            chk("t5_rsp_rdata", rsp_rdata, v_write[k] ? 32'h0 : v_rdata[k]);
            if (k == 3) cmd_valid = 1'b0;
        end
        tick();
        chk1("t5_idle_after", psel, 1'b0);
        chk1("t5_no_extra_rsp", rsp_valid, 1'b0);

        // ---------------- 6: reset during ACCESS ----------------
        drive_cmd(1'b0, 16'h0040, 32'h0);
        pready = 1'b0;
        tick();  // SETUP
        cmd_valid = 1'b0;
        tick();  // ACCESS
        chk1("t6_in_access", penable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_psel", psel, 1'b0);
        chk1("t6_rst_penable", penable, 1'b0);
        chk1("t6_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("t6_rst_ready", cmd_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk1("t6_post_rsp_valid", rsp_valid, 1'b0);
        chk1("t6_post_ready", cmd_ready, 1'b1);
        chk("t6_post_state", 32'(state), 32'h0);
        drive_cmd(1'b1, 16'h0050, 32'h0BADF00D);
        pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t6_w_paddr", 32'(paddr), 32'h0050);
        chk("t6_w_pwdata", pwdata, 32'h0BADF00D);
        tick();
        tick();
        chk1("t6_w_rsp_valid", rsp_valid, 1'b1);
        chk1("t6_w_rsp_err", rsp_err, 1'b0);
        chk1("t6_w_rsp_timeout", rsp_timeout, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
